// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - mode encoding shared by the universal shift register and its users
package usr_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_frame_counter.sv
// rtl/shift_frame_counter.sv - counts shifts and pulses done once every WIDTH shifts
module shift_frame_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic shift,
  input  logic clear,
  output logic done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  // clear (load) discards a partial frame exactly like reset does
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (shift) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        done <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        done <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - parametrised shift register with load, rotate, enable and frame pulse
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int ROTATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si_r,
  input  logic             si_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             so_r,
  output logic             so_l,
  output logic             done
);

  logic [WIDTH-1:0] q;
  mode_t            op;
  logic             fill_r;
  logic             fill_l;
  logic             do_shift;
  logic             do_load;

  always_comb begin
    op = en ? mode_t'(mode) : MODE_HOLD;
  end

  // in rotate mode the serial inputs are ignored and the outgoing bit recirculates
  assign fill_r   = (ROTATE != 0) ? q[0]       : si_r;
  assign fill_l   = (ROTATE != 0) ? q[WIDTH-1] : si_l;
  assign do_shift = (op == MODE_SHR) || (op == MODE_SHL);
  assign do_load  = (op == MODE_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (op)
        MODE_SHR:  q <= {fill_r, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], fill_l};
        MODE_LOAD: q <= pin;
        default:   q <= q;
      endcase
    end
  end

  assign pout = q;
  assign so_r = q[0];
  assign so_l = q[WIDTH-1];

  shift_frame_counter #(.WIDTH(WIDTH)) u_frame (
    .clk   (clk),
    .rst   (rst),
    .shift (do_shift),
    .clear (do_load),
    .done  (done)
  );

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - randomized and directed check of universal_shift_reg against a reference model
module tb_universal_shift_reg;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, si_r, si_l;
  logic [1:0]   mode;
  logic [W-1:0] pin;
  logic [W-1:0] p0, p1;
  logic         sr0, sl0, d0, sr1, sl1, d1;

  int total = 0;
  int bad   = 0;

  int m_q    [2];
  int m_cnt  [2];
  int m_done [2];

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(W), .ROTATE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .si_r(si_r), .si_l(si_l),
    .pin(pin), .pout(p0), .so_r(sr0), .so_l(sl0), .done(d0)
  );

  universal_shift_reg #(.WIDTH(W), .ROTATE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .si_r(si_r), .si_l(si_l),
    .pin(pin), .pout(p1), .so_r(sr1), .so_l(sl1), .done(d1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: register as an integer, frame progress as a shift tally modulo W
  task automatic model_edge(input int k, input logic r, e, input logic [1:0] m,
                            input logic sr, sl, input logic [W-1:0] p);
    int top, bot, fill;
    top = (m_q[k] >> (W - 1)) & 1;
    bot = m_q[k] & 1;
    if (r) begin
      m_q[k] = 0; m_cnt[k] = 0; m_done[k] = 0;
    end else if (!e || m == 2'd0) begin
      m_done[k] = 0;
    end else if (m == 2'd3) begin
      m_q[k] = int'(p); m_cnt[k] = 0; m_done[k] = 0;
    end else begin
      if (m == 2'd1) begin
        fill = (k == 1) ? bot : int'(sr);
        m_q[k] = (m_q[k] >> 1) + fill * (1 << (W - 1));
      end else begin
        fill = (k == 1) ? top : int'(sl);
        m_q[k] = ((m_q[k] * 2) % (1 << W)) + fill;
      end
      m_cnt[k] = m_cnt[k] + 1;
      m_done[k] = (m_cnt[k] == W) ? 1 : 0;
      if (m_cnt[k] == W) m_cnt[k] = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pout0"}, 32'(p0),  32'(m_q[0]));
    check({tag, ".sor0"},  32'(sr0), 32'(m_q[0] & 1));
    check({tag, ".sol0"},  32'(sl0), 32'((m_q[0] >> (W - 1)) & 1));
    check({tag, ".done0"}, 32'(d0),  32'(m_done[0]));
    check({tag, ".pout1"}, 32'(p1),  32'(m_q[1]));
    check({tag, ".sor1"},  32'(sr1), 32'(m_q[1] & 1));
    check({tag, ".sol1"},  32'(sl1), 32'((m_q[1] >> (W - 1)) & 1));
    check({tag, ".done1"}, 32'(d1),  32'(m_done[1]));
  endtask

  task automatic step(input string tag, input logic r, e, input logic [1:0] m,
                      input logic sr, sl, input logic [W-1:0] p);
    rst = r; en = e; mode = m; si_r = sr; si_l = sl; pin = p;
    @(posedge clk);
    model_edge(0, r, e, m, sr, sl, p);
    model_edge(1, r, e, m, sr, sl, p);
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [3:0] sipo_bits;
    logic [3:0] sipo_exp [4];
    logic [3:0] rot_exp  [4];
    logic [3:0] so_l_exp;
    logic       r, e, sr, sl;
    logic [1:0] m;
    logic [W-1:0] p;

    sipo_bits   = 4'b1101;
    sipo_exp[0] = 4'b1000; sipo_exp[1] = 4'b0100; sipo_exp[2] = 4'b1010; sipo_exp[3] = 4'b1101;
    rot_exp[0]  = 4'b1000; rot_exp[1]  = 4'b0100; rot_exp[2]  = 4'b0010; rot_exp[3]  = 4'b0001;
    so_l_exp    = 4'b1001;
    for (int k = 0; k < 2; k++) begin m_q[k] = 0; m_cnt[k] = 0; m_done[k] = 0; end
    rst = 1'b1; en = 1'b1; mode = 2'b11; si_r = 1'b0; si_l = 1'b0; pin = 4'hF;
    @(negedge clk);

    // reset holds with load pending
    step("reset_a", 1, 1, 2'b11, 0, 0, 4'hF);
    step("reset_b", 1, 1, 2'b11, 0, 0, 4'hF);
    check("reset_pout", 32'(p0), 32'h0);
    check("reset_done", 32'(d0), 32'h0);

    // SIPO right, si_r = 1,0,1,1
    for (int i = 0; i < 4; i++) begin
      step("sipo", 0, 1, 2'b01, sipo_bits[i], 0, 4'h0);
      check("sipo_pout", 32'(p0), 32'(sipo_exp[i]));
      check("sipo_done", 32'(d0), (i == 3) ? 32'd1 : 32'd0);
    end
    check("sipo_sor", 32'(sr0), 32'd1);
    step("sipo_after", 0, 1, 2'b00, 0, 0, 4'h0);
    check("sipo_done_drop", 32'(d0), 32'd0);

    // PISO left from 1001
    step("piso_load", 0, 1, 2'b11, 0, 0, 4'b1001);
    for (int i = 0; i < 4; i++) begin
      check("piso_sol", 32'(sl0), 32'(so_l_exp[3 - i]));
      step("piso", 0, 1, 2'b10, 0, 0, 4'h0);
    end
    check("piso_final", 32'(p0), 32'h0);
    check("piso_rot_final", 32'(p1), 32'h9);

    // hold and disable mid-frame
    step("hm_load", 0, 1, 2'b11, 0, 0, 4'h0);
    step("hm_s1", 0, 1, 2'b01, 1, 0, 4'h0);
    step("hm_s2", 0, 1, 2'b01, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) step("hm_en0", 0, 0, 2'b01, 1, 1, 4'hF);
    for (int i = 0; i < 2; i++) step("hm_hold", 0, 1, 2'b00, 1, 1, 4'hF);
    check("hm_frozen", 32'(p0), 32'h4);
    step("hm_s3", 0, 1, 2'b01, 1, 0, 4'h0);
    check("hm_no_done", 32'(d0), 32'd0);
    step("hm_s4", 0, 1, 2'b01, 1, 0, 4'h0);
    check("hm_done", 32'(d0), 32'd1);

    // rotate: si_r ignored
    step("rot_load", 0, 1, 2'b11, 0, 0, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      step("rot", 0, 1, 2'b01, 1, 1, 4'h0);
      check("rot_pout", 32'(p1), 32'(rot_exp[i]));
      check("rot_done", 32'(d1), (i == 3) ? 32'd1 : 32'd0);
    end

    // reset and load mid-frame discard the partial count
    for (int i = 0; i < 3; i++) step("mid_s", 0, 1, 2'b10, 1, 1, 4'h0);
    step("mid_rst", 1, 1, 2'b01, 0, 0, 4'h0);
    check("mid_rst_pout", 32'(p0), 32'h0);
    for (int i = 0; i < 4; i++) step("mid_after_rst", 0, 1, 2'b01, 1, 0, 4'h0);
    check("mid_rst_done", 32'(d0), 32'd1);
    for (int i = 0; i < 3; i++) step("mid_s2", 0, 1, 2'b01, 0, 0, 4'h0);
    step("mid_load", 0, 1, 2'b11, 0, 0, 4'hA);
    check("mid_load_pout", 32'(p0), 32'hA);
    for (int i = 0; i < 3; i++) begin
      step("mid_after_load", 0, 1, 2'b10, 0, 1, 4'h0);
      check("mid_load_nodone", 32'(d0), 32'd0);
    end
    step("mid_after_load4", 0, 1, 2'b01, 0, 1, 4'h0);
    check("mid_load_done", 32'(d0), 32'd1);

    // randomized traffic, shift-heavy so frames complete often
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      e  = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 9))
        0:       m = 2'b00;
        1:       m = 2'b11;
        2, 3, 4: m = 2'b10;
        default: m = 2'b01;
      endcase
      sr = 1'($urandom);
      sl = 1'($urandom);
      p  = W'($urandom);
      step("rand", r, e, m, sr, sl, p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised universal shift register, the successor to the team's fixed 4-bit serial-in/serial-out register.
- Adds configurable width, bidirectional shifting, parallel load, optional rotate, clock enable and a frame-complete counter.
- Sits between serial links (UART/SPI-style bit streams) and parallel datapaths, in both SIPO and PISO roles.

Parameters:
WIDTH, 4, register width in bits (>=2).
ROTATE, 0, 1 = shifts recirculate the outgoing bit and ignore the serial inputs; 0 = serial inputs feed the vacated bit.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
en  input  1  clock enable; 0 forces hold regardless of mode.
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
si_r  input  1  serial in for shift right; enters bit WIDTH-1.
si_l  input  1  serial in for shift left; enters bit 0.
pin  input  WIDTH  parallel load data.
pout  output  WIDTH  register contents q.
so_r  output  1  q[0] (right-shift serial out).
so_l  output  1  q[WIDTH-1] (left-shift serial out).
done  output  1  one-cycle pulse: WIDTH shifts completed since the last load or reset.

Behaviour:
Register update
- All state updates on posedge clk. rst has priority over en and mode.
- Reset: q=0, cnt=0, done=0. Hence pout=0, so_r=0, so_l=0.
- Effective op = hold when en=0, otherwise decoded from mode.
- Hold: q, cnt unchanged; done=0.
- Shift right: q[i]<=q[i+1] for i<WIDTH-1; q[WIDTH-1]<=si_r (ROTATE=0) or q[0] (ROTATE=1).
- Shift left: q[i]<=q[i-1] for i>0; q[0]<=si_l (ROTATE=0) or q[WIDTH-1] (ROTATE=1).
- Load: q<=pin; cnt<=0; done<=0.

Latency and outputs
- pout/so_r/so_l are combinational from q, giving one-cycle latency from input to register.
- A bit entering on si_r appears at so_r after WIDTH right shifts.

Frame counter
- cnt is $clog2(WIDTH) bits wide and counts shifts in either direction.
- On a shift with cnt==WIDTH-1: cnt<=0 and done<=1. Wrap-around is continuous, so back-to-back frames produce a pulse every WIDTH shifts.
- On any other shift: cnt<=cnt+1, done<=0.
- done is registered: high for exactly the one cycle after the edge that performs the WIDTH-th shift, then low unless the next edge completes another frame (possible only when WIDTH=... never for WIDTH>=2).
- Mixed left/right shifts within a frame all count.
- Hold or en=0 mid-frame preserves cnt; done drops to 0.
- Reset or load mid-frame discards the partial count.

Decomposition:
- Package usr_pkg: mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11, plus a 2-bit mode typedef.
- Sub-module shift_frame_counter (WIDTH param; inputs clk, rst, shift, clear; output done) isolates cnt/done so it can be reused by the team's serial blocks.
- Data path stays in the top module.

Test Plan:
1. Reset: WIDTH=4, ROTATE=0, rst=1 for 2 cycles with mode=11, pin=4'hF -> pout=4'h0, so_r=0, so_l=0, done=0.
2. SIPO right: en=1, mode=01, si_r=1,0,1,1 on 4 edges -> pout 1000, 0100, 1010, 1101; done=1 only in the cycle after the 4th edge; so_r=1.
3. PISO left: load pin=4'b1001, then mode=10, si_l=0 for 4 edges -> so_l sequence 1,0,0,1 before each edge; final pout=0000; done pulse once.
4. Hold/enable mid-frame: after 2 right shifts, set en=0 for 3 cycles, then mode=00 for 2 cycles, then 2 more shifts -> pout frozen during hold; done asserts only after the 4th actual shift.
5. Rotate: ROTATE=1, load 4'b0001, then 4 right shifts with si_r=1 -> pout 1000, 0100, 0010, 0001 (si_r ignored); done pulse once.
6. Reset/load mid-frame: after 3 shifts, assert rst one cycle (or load 4'hA) -> pout=0 (or 4'hA), done=0; the next done occurs only after 4 further shifts.
